// File: rtl/l2_line_mem_responder_if.sv
// rtl/l2_line_mem_responder_if.sv - L2 line request/response bus between cache and memory responder
// The L2 drives the master side and the memory responder sits on the slave side.
interface l2_line_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         protocol_error;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, protocol_error
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata, protocol_error
    );
endinterface

// File: rtl/l2_line_mem_responder.sv
// rtl/l2_line_mem_responder.sv - fixed-latency 128-bit line store answering L2 line reads and writes
// The store itself has no reset so memory contents survive a controller reset.
module l2_line_mem_responder #(
    parameter int LATENCY = 10,
    parameter int LINES   = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    l2_line_mem_responder_if.slave mem
);
    localparam int IDXW = $clog2(LINES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [11:0]  line_q, line_d;
    logic         wr_q, wr_d;
    logic [127:0] wdata_q, wdata_d;
    logic [127:0] rdata_q, rdata_d;
    logic         perr_q, perr_d;
    logic         held_strobe;

    logic [127:0] store [LINES];

    assign held_strobe = wr_q ? mem.mem_write : mem.mem_read;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            S_IDLE: begin
                if (mem.mem_read || mem.mem_write) begin
                    line_d = mem.mem_address[15:4];
                    // Both strobes together is illegal; serve it as the harmless op, a read.
                    wr_d   = mem.mem_write && !mem.mem_read;
                    if (mem.mem_read && mem.mem_write) begin
                        perr_d = 1'b1;
                    end
                    if (mem.mem_write && !mem.mem_read) begin
                        wdata_d = mem.mem_wdata;
                    end
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (!held_strobe) begin
                    state_d = S_IDLE;
                end else begin
                    if (mem.mem_address[15:4] != line_q) begin
                        perr_d = 1'b1;
                    end
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:    state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Load read data on entry to RESP so it is already registered in the pulse cycle.
        if (state_d == S_RESP && state_q != S_RESP && !wr_d) begin
            rdata_d = store[line_d[IDXW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_RESP && wr_q) begin
            store[line_q[IDXW-1:0]] <= wdata_q;
        end
    end

    assign mem.mem_resp       = (state_q == S_RESP);
    assign mem.mem_rdata      = rdata_q;
    assign mem.protocol_error = perr_q;
endmodule

// File: tb/tb_l2_line_mem_responder.sv
// tb/tb_l2_line_mem_responder.sv - scoreboard bench for l2_line_mem_responder at LATENCY 10 and 1
// Expected responses are queued when a request is issued and matched when mem_resp pulses.
module tb_l2_line_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   resp_cnt0 = 0;
    int   resp_cnt1 = 0;

    typedef struct {
        int           cyc;
        logic         chk_data;
        logic [127:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    localparam logic [127:0] DATA_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DATA_B = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] DATA_C = 128'hC0C0_C0C0_1212_3434_5656_7878_9A9A_BCBC;
    localparam logic [127:0] DATA_D = 128'h0F0F_0F0F_A5A5_5A5A_1357_2468_ACE0_BDF1;
    localparam logic [127:0] JUNK   = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

    l2_line_mem_responder_if bus0();
    l2_line_mem_responder_if bus1();

    l2_line_mem_responder #(.LATENCY(10), .LINES(4096)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (bus0)
    );

    l2_line_mem_responder #(.LATENCY(1), .LINES(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus0.mem_resp) begin
            resp_cnt0++;
            if (q0.size() == 0) begin
                check_eq("spurious_resp0", 1, 0);
            end else begin
                e = q0.pop_front();
                check_eq("resp_cycle0", edge_n + 1, e.cyc);
                if (e.chk_data) check_eq("rdata0", bus0.mem_rdata, e.data);
            end
        end
        if (rst_n && bus1.mem_resp) begin
            resp_cnt1++;
            if (q1.size() == 0) begin
                check_eq("spurious_resp1", 1, 0);
            end else begin
                e = q1.pop_front();
                check_eq("resp_cycle1", edge_n + 1, e.cyc);
                if (e.chk_data) check_eq("rdata1", bus1.mem_rdata, e.data);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input bit w, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [127:0] d);
        if (w) begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_address = a; bus1.mem_wdata = d;
        end else begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_address = a; bus0.mem_wdata = d;
        end
    endtask

    task automatic push_exp(input bit w, input int cyc, input logic chk, input logic [127:0] d);
        exp_t e;
        e.cyc = cyc; e.chk_data = chk; e.data = d;
        if (w) q1.push_back(e); else q0.push_back(e);
    endtask

    // Issue a request sampled at the next edge; returns that acceptance edge.
    task automatic start(input bit w, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [127:0] d, input bit push, output int acc);
        set_req(w, rd, wr, a, d);
        acc = edge_n + 1;
        if (push) push_exp(w, acc + (w ? 1 : 10), rd, DATA_A);
    endtask

    task automatic start_rd(input bit w, input logic [15:0] a, input logic [127:0] exp, output int acc);
        set_req(w, 1'b1, 1'b0, a, '0);
        acc = edge_n + 1;
        push_exp(w, acc + (w ? 1 : 10), 1'b1, exp);
    endtask

    task automatic wait_resp(input bit w, input string tag);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick(1);
            seen = w ? bus1.mem_resp : bus0.mem_resp;
        end
        if (!seen) check_eq(tag, 0, 1);
    endtask

    task automatic drop(input bit w);
        set_req(w, 1'b0, 1'b0, '0, '0);
        tick(2);
    endtask

    task automatic txn_wr(input bit w, input logic [15:0] a, input logic [127:0] d);
        int acc;
        start(w, 1'b0, 1'b1, a, d, 1'b1, acc);
        wait_resp(w, "wr_timeout");
        drop(w);
    endtask

    task automatic txn_rd(input bit w, input logic [15:0] a, input logic [127:0] exp);
        int acc;
        start_rd(w, a, exp, acc);
        wait_resp(w, "rd_timeout");
        drop(w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int acc;
        int saved;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        tick(3);
        check_eq("reset_resp", bus0.mem_resp, 0);
        check_eq("reset_rdata", bus0.mem_rdata, 0);
        check_eq("reset_perr", bus0.protocol_error, 0);
        rst_n = 1'b1;
        tick(1);

        txn_wr(0, 16'h1230, DATA_A);
        do_reset();

        start_rd(0, 16'h1230, DATA_A, acc);
        tick(9);
        check_eq("pre_pulse_resp", bus0.mem_resp, 0);
        check_eq("pre_pulse_rdata", bus0.mem_rdata, 0);
        wait_resp(0, "first_rd_timeout");
        drop(0);

        txn_wr(0, 16'h4A70, DATA_B);
        txn_rd(0, 16'h4A7F, DATA_B);

        start_rd(0, 16'h4A70, DATA_B, acc);
        push_exp(0, acc + 10 + 2 + 10, 1'b1, DATA_B);
        wait_resp(0, "held_first_timeout");
        wait_resp(0, "held_second_timeout");
        drop(0);

        saved = resp_cnt0;
        start(0, 1'b0, 1'b1, 16'h4A70, DATA_C, 1'b0, acc);
        tick(5);
        set_req(0, 0, 0, '0, '0);
        tick(15);
        check_eq("abort_no_resp", resp_cnt0, saved);
        txn_rd(0, 16'h4A70, DATA_B);

        saved = resp_cnt0;
        start(0, 1'b0, 1'b1, 16'h4A70, DATA_C, 1'b0, acc);
        tick(4);
        rst_n = 1'b0;
        set_req(0, 0, 0, '0, '0);
        #1;
        check_eq("midbusy_reset_resp", bus0.mem_resp, 0);
        check_eq("midbusy_reset_rdata", bus0.mem_rdata, 0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        check_eq("midbusy_reset_no_resp", resp_cnt0, saved);
        txn_rd(0, 16'h4A70, DATA_B);
        check_eq("perr_clean", bus0.protocol_error, 0);

        set_req(0, 1'b1, 1'b1, 16'h1230, JUNK);
        push_exp(0, edge_n + 1 + 10, 1'b1, DATA_A);
        wait_resp(0, "both_timeout");
        drop(0);
        check_eq("both_perr", bus0.protocol_error, 1);
        txn_rd(0, 16'h1230, DATA_A);
        do_reset();
        check_eq("perr_after_reset", bus0.protocol_error, 0);

        start_rd(0, 16'h4A70, DATA_B, acc);
        tick(3);
        bus0.mem_address = 16'h1230;
        wait_resp(0, "addr_change_timeout");
        drop(0);
        check_eq("addr_change_perr", bus0.protocol_error, 1);
        txn_rd(0, 16'h1230, DATA_A);
        tick(5);
        check_eq("perr_sticky", bus0.protocol_error, 1);
        do_reset();
        check_eq("perr_cleared", bus0.protocol_error, 0);

        txn_wr(1, 16'h0030, DATA_D);
        start_rd(1, 16'h1030, DATA_D, acc);
        push_exp(1, acc + 4, 1'b1, DATA_D);
        push_exp(1, acc + 7, 1'b1, DATA_D);
        wait_resp(1, "l1_first_timeout");
        wait_resp(1, "l1_second_timeout");
        wait_resp(1, "l1_third_timeout");
        drop(1);
        tick(3);

        check_eq("q0_drained", q0.size(), 0);
        check_eq("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
